// File: rtl/jtframe_joyser_tx.sv
// jtframe_joyser_tx: serial joystick responder emulating the PISO shift chain on JOY_DATA.
// Strobes are synchronised to clk; a load always wins over a simultaneous clock edge.
module jtframe_joyser_tx #(
    parameter int   NBITS    = 16,
    parameter int   SYNC     = 2,
    parameter logic LOAD_ACT = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NBITS-1:0] par_din,
    input  logic             joy_clk_i,
    input  logic             joy_load_i,
    output logic             joy_data_o,
    output logic             busy,
    output logic             frame_done,
    output logic [7:0]       frame_cnt
);
    localparam int CW = $clog2(NBITS + 1);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    state_t           state_q, state_d;
    logic [SYNC-1:0]  ck_sync_q, ck_sync_d;
    logic [SYNC-1:0]  ld_sync_q, ld_sync_d;
    logic             ck_dly_q, ck_dly_d;
    logic [NBITS-1:0] sr_q, sr_d;
    logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
    logic             frame_done_q, frame_done_d;
    logic [7:0]       frame_cnt_q, frame_cnt_d;
    logic             ld, ck_rise;

    assign ld         = ld_sync_q[SYNC-1] == LOAD_ACT;
    assign ck_rise    = ck_sync_q[SYNC-1] & ~ck_dly_q;
    assign joy_data_o = sr_q[NBITS-1];
    assign busy       = state_q == SHIFT;
    assign frame_done = frame_done_q;
    assign frame_cnt  = frame_cnt_q;

    always_comb begin
        ck_sync_d    = {ck_sync_q[SYNC-2:0], joy_clk_i};
        ld_sync_d    = {ld_sync_q[SYNC-2:0], joy_load_i};
        ck_dly_d     = ck_sync_q[SYNC-1];
        state_d      = state_q;
        sr_d         = sr_q;
        bit_cnt_d    = bit_cnt_q;
        frame_done_d = 1'b0;
        frame_cnt_d  = frame_cnt_q;
        if (ld) begin
            state_d   = LOAD;
            sr_d      = par_din;
            bit_cnt_d = '0;
        end else begin
            case (state_q)
                IDLE: state_d = IDLE;
                LOAD: state_d = SHIFT;
                SHIFT: if (ck_rise) begin
                    sr_d      = {sr_q[NBITS-2:0], 1'b1};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == CW'(NBITS - 1)) begin
                        frame_done_d = 1'b1;
                        frame_cnt_d  = frame_cnt_q + 8'd1;
                        state_d      = DONE;
                    end
                end
                // keep shifting the tied-high serial input so the line idles at 1
                DONE: sr_d = ck_rise ? {sr_q[NBITS-2:0], 1'b1} : sr_q;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ck_sync_q    <= '0;
            ld_sync_q    <= {SYNC{~LOAD_ACT}};
            ck_dly_q     <= 1'b0;
            state_q      <= IDLE;
            sr_q         <= '1;
            bit_cnt_q    <= '0;
            frame_done_q <= 1'b0;
            frame_cnt_q  <= '0;
        end else begin
            ck_sync_q    <= ck_sync_d;
            ld_sync_q    <= ld_sync_d;
            ck_dly_q     <= ck_dly_d;
            state_q      <= state_d;
            sr_q         <= sr_d;
            bit_cnt_q    <= bit_cnt_d;
            frame_done_q <= frame_done_d;
            frame_cnt_q  <= frame_cnt_d;
        end
    end
endmodule

// File: tb/tb_jtframe_joyser_tx.sv
// tb_jtframe_joyser_tx: frame-level checks of the joystick responder against a word-shift model.
module tb_jtframe_joyser_tx;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] par_din;
    logic        joy_clk_i, joy_load_i;
    logic        joy_data_o, busy, frame_done;
    logic [7:0]  frame_cnt;

    typedef struct {
        logic [15:0] par;
        int          np;
        bit          exp_done;
    } vec_t;

    vec_t        tbl[7];
    int          vec = 0, err = 0, done_seen = 0, done_exp = 0, base;
    logic [7:0]  fc;
    logic        cur;

    jtframe_joyser_tx #(.NBITS(16), .SYNC(2), .LOAD_ACT(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .par_din(par_din), .joy_clk_i(joy_clk_i),
        .joy_load_i(joy_load_i), .joy_data_o(joy_data_o), .busy(busy),
        .frame_done(frame_done), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (frame_done === 1'b1) done_seen++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic load(input logic [15:0] par);
        par_din    = par;
        joy_load_i = 1'b0;
        repeat (2) @(negedge clk);
        chk("load_pre", joy_data_o, cur);
        @(negedge clk);
        chk("load_msb", joy_data_o, par[15]);
        cur = par[15];
        repeat (5) @(negedge clk);
        joy_load_i = 1'b1;
        repeat (4) @(negedge clk);
        chk("busy_after_load", busy, 1);
        par_din = 16'($urandom);
    endtask

    task automatic pulse(input logic exp, input int h);
        joy_clk_i = 1'b1;
        repeat (2) @(negedge clk);
        chk("bit_pre", joy_data_o, cur);
        @(negedge clk);
        chk("bit", joy_data_o, exp);
        cur = exp;
        repeat (h - 3) @(negedge clk);
        joy_clk_i = 1'b0;
        repeat (h) @(negedge clk);
    endtask

    task automatic shift_out(input logic [15:0] par, input int np, input int h, input bit exp_done);
        logic [15:0] w;
        w = par;
        for (int i = 1; i <= np; i++) begin
            w = {w[14:0], 1'b1};
            pulse(w[15], h);
        end
        fc       = fc + 8'(exp_done);
        done_exp = done_exp + int'(exp_done);
        chk("frame_cnt", frame_cnt, fc);
        chk("done_pulses", done_seen, done_exp);
        chk("busy_end", busy, !exp_done);
    endtask

    task automatic run_frame(input logic [15:0] par, input int np, input int h, input bit exp_done);
        load(par);
        shift_out(par, np, h, exp_done);
    endtask

    initial begin
        tbl[0] = '{16'hA5C3, 20, 1'b1};
        tbl[1] = '{16'h0F0F, 5, 1'b0};
        tbl[2] = '{16'h0F0F, 16, 1'b1};
        tbl[3] = '{16'hFFFF, 0, 1'b0};
        tbl[4] = '{16'h0000, 16, 1'b1};
        tbl[5] = '{16'h8001, 15, 1'b0};
        tbl[6] = '{16'h7FFE, 17, 1'b1};
        rst_n = 1'b0; joy_clk_i = 1'b0; joy_load_i = 1'b1; par_din = '0;
        fc = '0; cur = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_data", joy_data_o, 1);
        chk("rst_busy", busy, 0);
        chk("rst_cnt", frame_cnt, 0);
        chk("rst_done", frame_done, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (i % 5 == 0) joy_clk_i = ~joy_clk_i;
            @(negedge clk);
            chk("idle_data", joy_data_o, 1);
            chk("idle_busy", busy, 0);
            chk("idle_cnt", frame_cnt, 0);
        end
        for (int i = 0; i < 7; i++) run_frame(tbl[i].par, tbl[i].np, 8, tbl[i].exp_done);
        // load and clock edge reach the core on the same cycle: edge must not count
        run_frame(16'h1234, 3, 8, 1'b0);
        par_din = 16'hC3A5; joy_load_i = 1'b0; joy_clk_i = 1'b1;
        repeat (2) @(negedge clk);
        chk("sim_pre", joy_data_o, cur);
        @(negedge clk);
        chk("sim_msb", joy_data_o, 1);
        cur = 1'b1;
        repeat (5) @(negedge clk);
        joy_clk_i = 1'b0;
        repeat (3) @(negedge clk);
        joy_load_i = 1'b1;
        repeat (4) @(negedge clk);
        shift_out(16'hC3A5, 15, 8, 1'b0);
        pulse(1'b1, 8);
        fc++; done_exp++;
        chk("sim_cnt", frame_cnt, fc);
        chk("sim_done", done_seen, done_exp);
        for (int i = 0; i < 12; i++) begin
            int np;
            np = int'($urandom_range(0, 20));
            run_frame(16'($urandom), np, 8, np >= 16);
        end
        run_frame(16'h5A5A, 7, 8, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        fc = '0; cur = 1'b1;
        chk("mid_rst_data", joy_data_o, 1);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_cnt", frame_cnt, 0);
        for (int i = 0; i < 3; i++) pulse(1'b1, 8);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_cnt", frame_cnt, 0);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        base = done_seen;
        for (int i = 0; i < 256; i++) run_frame(16'($urandom), 16, 4, 1'b1);
        chk("wrap_cnt", frame_cnt, 0);
        chk("wrap_pulses", done_seen - base, 256);
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end
endmodule
